ternary_vector_engine_mc: RTL
=============================

// Module: ternary_vector_engine_mc
// PURPOSE
//  Next-gen TFM SIMD ternary MAC engine: LANES parallel lanes, NUM_CTX independent accumulator contexts.
//  Consumes a valid/ready stream of unpacked trit beats for a job of job_len beats into one selected context.
//  FSM-sequenced, with a saturating signed accumulator per lane, a per-context random-access readback port and profiling.
//  Sits between the PT-5 unpacking bus controller and the result DMA.
// PARAMETERS
//  LANES        16  SIMD lanes (1..64)
//  NUM_CTX      4   accumulator contexts (power of 2, >=2); CTX_W = $clog2(NUM_CTX)
//  ACCUM_WIDTH  32  signed accumulator width per lane (>=8)
// PORTS
//  clk               in   1            clock
//  reset             in   1            synchronous, active-high reset
//  start             in   1            job start pulse; honoured only in IDLE
//  ctx_sel           in   CTX_W        target context, latched at start
//  job_len           in   16           beats in job, latched at start
//  exec_hints        in   32           [19] weight broadcast, [20] clear ctx at start, [21] saturate enable; latched at start
//  lane_count        in   16           lanes >= lane_count inactive; latched at start
//  lane_mask         in   LANES        per-lane enable; latched at start
//  in_valid          in   1            beat valid
//  in_ready          out  1            engine accepts beat
//  bus_weights       in   2*LANES      trit per lane
//  bus_inputs        in   2*LANES      trit per lane
//  busy              out  1            FSM not IDLE
//  done              out  1            one-cycle pulse at job end
//  rd_en             in   1            readback request
//  rd_ctx            in   CTX_W        readback context
//  rd_lane           in   8            readback lane
//  rd_valid          out  1            rd_data valid (1 cycle after rd_en)
//  rd_data           out  ACCUM_WIDTH  accumulator value
//  sat_flags         out  LANES        sticky per-lane saturation of current job
//  cycle_count       out  32           cycles spent in RUN
//  stall_count       out  32           RUN cycles with in_valid=0
//  utilization_count out  32           sum of active lanes over accepted beats
// BEHAVIOUR
//  - Trit encoding: 2'b00=0, 2'b01=+1, 2'b10=-1, 2'b11 reserved = 0. Product = w*x in {-1,0,+1}.
//  - Reset: FSM IDLE; all accumulators, counters, sat_flags, rd_data = 0; in_ready, busy, done, rd_valid = 0.
//  - FSM IDLE -> RUN on start & job_len!=0; IDLE -> DONE on start & job_len==0 (no beats, done next cycle).
//    RUN -> DONE on accepted beat with beat_cnt == job_len-1. DONE (done=1 one cycle) -> IDLE.
//  - start outside IDLE ignored; latched config unchanged.
//  - Start cycle: latch config; clear sat_flags; if hint[20], zero all lanes of ctx_sel. Counters not cleared (free-run, wrap at 2^32).
//  - in_ready = 1 only in RUN. Beat accepted when in_valid & in_ready. Accepted beat updates accumulators at that clock edge.
//  - Lane active = (i < lane_count) & lane_mask[i]. Inactive lanes hold value.
//  - hint[19]: every lane uses bus_weights[1:0].
//  - Accumulate: acc + product. hint[21]=1 clamps to [-2^(AW-1), 2^(AW-1)-1] and sets sat_flags[i] on clamp.
//    hint[21]=0 wraps two's complement; no flag.
//  - Per RUN cycle: cycle_count+1; also stall_count+1 if !in_valid; accepted beat adds popcount(active lanes) to utilization_count.
//  - Readback: rd_en registered -> rd_valid=1 and rd_data next cycle. Same-cycle write to that lane returns pre-update value.
//    rd_lane >= LANES returns 0 with rd_valid=1. Readback is legal in any state.
//  - Contexts other than the latched ctx are never modified by a job.
//  - Reset mid-job: immediate return to IDLE with full reset values; no done pulse.
// STRUCTURE
//  - tfm_pkg: trit encoding localparams (TRIT_ZERO/POS/NEG), hint bit indices (HINT_BRDCST=19, HINT_CLR=20, HINT_SAT=21), FSM state enum.
//  - Sub-module ternary_mac_lane: trit decode, product, saturating/wrapping add, sat flag. Instanced LANES times.
//  - Top: FSM, config latches, NUM_CTX x LANES accumulator array, readback mux, profiling counters.
// TESTING
//  1. LANES=16, ctx0, job_len=4, all weights +1, inputs +1, mask all -> done in cycle after 4th beat; every lane reads 4; utilization +64.
//  2. in_valid toggled 1,0,0,1,1 over 3 beats -> stall_count +2, cycle_count +5; result unaffected.
//  3. AW=8, hint[21]=1, 200 beats of +1*+1 -> lane reads 127, sat_flags all 1. Same with hint[21]=0 -> reads -56 (wrap), no flag.
//  4. lane_count=5, lane_mask=16'h00FF, hint[19]=1, bus_weights[1:0]=2'b10, inputs +1, 3 beats -> lanes0-4 = -3, others unchanged.
//  5. job into ctx1 with hint[20]=0 after prior job -> ctx1 accumulates onto old value; ctx0/2/3 unchanged. With hint[20]=1 -> restarts from 0.
//  6. job_len=0 -> done 1 cycle after start, in_ready never 1. Start while busy ignored. Reset at beat 2 -> busy=0, all reads 0, no done.

Source files
------------

// File: rtl/tfm_pkg.sv
// Shared definitions for the TFM ternary MAC engine: trit encoding, hint bit positions,
// sequencer states and the trit product helper.
package tfm_pkg;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b10;

  localparam int HINT_BRDCST = 19;
  localparam int HINT_CLR    = 20;
  localparam int HINT_SAT    = 21;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } tfm_state_e;

  // The reserved code 2'b11 decodes as zero.
  function automatic logic signed [1:0] trit_decode(input logic [1:0] t);
    case (t)
      TRIT_POS: return 2'sb01;
      TRIT_NEG: return 2'sb11;
      default:  return 2'sb00;
    endcase
  endfunction

  function automatic logic signed [1:0] trit_mul(input logic [1:0] w, input logic [1:0] x);
    logic signed [1:0] wv;
    logic signed [1:0] xv;
    wv = trit_decode(w);
    xv = trit_decode(x);
    if (wv == 2'sb00 || xv == 2'sb00) return 2'sb00;
    else if (wv == xv)                return 2'sb01;
    else                              return 2'sb11;
  endfunction

endpackage

// File: rtl/ternary_mac_lane.sv
// One SIMD lane: ternary product added to the lane accumulator, either clamped
// (reporting the clamp) or wrapping in two's complement.
module ternary_mac_lane
  import tfm_pkg::*;
#(
  parameter int ACCUM_WIDTH = 32
) (
  input  logic signed [ACCUM_WIDTH-1:0] acc_in,
  input  logic        [1:0]             weight,
  input  logic        [1:0]             act,
  input  logic                          sat_en,
  output logic signed [ACCUM_WIDTH-1:0] acc_out,
  output logic                          sat_hit
);

  logic signed [1:0]           prod_s;
  logic signed [ACCUM_WIDTH:0] sum_s;
  logic                        ovf_s;

  assign prod_s = trit_mul(weight, act);
  assign sum_s  = {acc_in[ACCUM_WIDTH-1], acc_in} + {{(ACCUM_WIDTH-1){prod_s[1]}}, prod_s};
  assign ovf_s  = sum_s[ACCUM_WIDTH] ^ sum_s[ACCUM_WIDTH-1];

  // Clamp toward the true sign of the widened sum when saturating, else wrap.
  always_comb begin
    acc_out = sum_s[ACCUM_WIDTH-1:0];
    sat_hit = 1'b0;
    if (sat_en && ovf_s) begin
      sat_hit = 1'b1;
      acc_out = sum_s[ACCUM_WIDTH] ? {1'b1, {(ACCUM_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
    end else begin
      sat_hit = 1'b0;
      acc_out = sum_s[ACCUM_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/ternary_vector_engine_mc.sv
// Multi-context SIMD ternary MAC engine: job sequencer, per-context lane accumulators,
// registered random-access readback and free-running profiling counters.
module ternary_vector_engine_mc
  import tfm_pkg::*;
#(
  parameter  int LANES       = 16,
  parameter  int NUM_CTX     = 4,
  parameter  int ACCUM_WIDTH = 32,
  localparam int CTX_W       = $clog2(NUM_CTX)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CTX_W-1:0]       ctx_sel,
  input  logic [15:0]            job_len,
  input  logic [31:0]            exec_hints,
  input  logic [15:0]            lane_count,
  input  logic [LANES-1:0]       lane_mask,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*LANES-1:0]     bus_weights,
  input  logic [2*LANES-1:0]     bus_inputs,
  output logic                   busy,
  output logic                   done,
  input  logic                   rd_en,
  input  logic [CTX_W-1:0]       rd_ctx,
  input  logic [7:0]             rd_lane,
  output logic                   rd_valid,
  output logic [ACCUM_WIDTH-1:0] rd_data,
  output logic [LANES-1:0]       sat_flags,
  output logic [31:0]            cycle_count,
  output logic [31:0]            stall_count,
  output logic [31:0]            utilization_count
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  tfm_state_e             state_r;
  logic [CTX_W-1:0]       ctx_r;
  logic [15:0]            job_len_r;
  logic [15:0]            lane_count_r;
  logic [LANES-1:0]       lane_mask_r;
  logic                   brd_r;
  logic                   sat_en_r;
  logic [15:0]            beat_cnt_r;
  logic                   in_ready_r;
  logic                   busy_r;
  logic                   done_r;
  logic [31:0]            cycle_r;
  logic [31:0]            stall_r;
  logic [31:0]            util_r;
  logic [LANES-1:0]       sat_flags_r;
  logic                   rd_valid_r;
  logic [ACCUM_WIDTH-1:0] rd_data_r;
  logic signed [ACCUM_WIDTH-1:0] acc_r [NUM_CTX][LANES];

  logic                          start_s;
  logic                          accept_s;
  logic [LANES-1:0]              active_s;
  logic [LANES-1:0]              lane_sat_s;
  logic signed [ACCUM_WIDTH-1:0] lane_acc_s [LANES];
  logic [31:0]                   util_inc_s;
  logic [LANE_W-1:0]             rd_idx_s;
  logic                          rd_lane_ok_s;
  logic                          unused_hints_s;

  assign start_s        = start & (state_r == ST_IDLE);
  assign accept_s       = in_valid & in_ready_r;
  assign rd_idx_s       = rd_lane[LANE_W-1:0];
  assign rd_lane_ok_s   = ({1'b0, rd_lane} < 9'(LANES));
  assign unused_hints_s = ^{exec_hints[31:22], exec_hints[18:0]};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [1:0] w_s;
    assign active_s[g] = (16'(g) < lane_count_r) & lane_mask_r[g];
    assign w_s         = brd_r ? bus_weights[1:0] : bus_weights[2*g +: 2];
    ternary_mac_lane #(.ACCUM_WIDTH(ACCUM_WIDTH)) u_lane (
      .acc_in  (acc_r[ctx_r][g]),
      .weight  (w_s),
      .act     (bus_inputs[2*g +: 2]),
      .sat_en  (sat_en_r),
      .acc_out (lane_acc_s[g]),
      .sat_hit (lane_sat_s[g])
    );
  end

  // Number of lanes an accepted beat actually exercises.
  always_comb begin
    util_inc_s = 32'd0;
    for (int i = 0; i < LANES; i++) begin
      util_inc_s = util_inc_s + {31'd0, active_s[i]};
    end
  end

  // Job sequencer with config latches, registered handshake/status and profiling.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      ctx_r        <= '0;
      job_len_r    <= 16'd0;
      lane_count_r <= 16'd0;
      lane_mask_r  <= '0;
      brd_r        <= 1'b0;
      sat_en_r     <= 1'b0;
      beat_cnt_r   <= 16'd0;
      in_ready_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      cycle_r      <= 32'd0;
      stall_r      <= 32'd0;
      util_r       <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            ctx_r        <= ctx_sel;
            job_len_r    <= job_len;
            lane_count_r <= lane_count;
            lane_mask_r  <= lane_mask;
            brd_r        <= exec_hints[HINT_BRDCST];
            sat_en_r     <= exec_hints[HINT_SAT];
            beat_cnt_r   <= 16'd0;
            busy_r       <= 1'b1;
            if (job_len == 16'd0) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r    <= ST_RUN;
              in_ready_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          cycle_r <= cycle_r + 32'd1;
          if (!in_valid) stall_r <= stall_r + 32'd1;
          if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + 16'd1;
            util_r     <= util_r + util_inc_s;
            if (beat_cnt_r == job_len_r - 16'd1) begin
              state_r    <= ST_DONE;
              in_ready_r <= 1'b0;
              done_r     <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  // Accumulator array and sticky saturation flags; only the latched context is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_flags_r <= '0;
      for (int c = 0; c < NUM_CTX; c++) begin
        for (int l = 0; l < LANES; l++) acc_r[c][l] <= '0;
      end
    end else if (start_s) begin
      sat_flags_r <= '0;
      if (exec_hints[HINT_CLR]) begin
        for (int l = 0; l < LANES; l++) acc_r[ctx_sel][l] <= '0;
      end
    end else if (accept_s) begin
      for (int l = 0; l < LANES; l++) begin
        if (active_s[l]) begin
          acc_r[ctx_r][l] <= lane_acc_s[l];
          sat_flags_r[l]  <= sat_flags_r[l] | lane_sat_s[l];
        end
      end
    end
  end

  // Readback sees the array before any same-edge write; out-of-range lanes read zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) rd_data_r <= rd_lane_ok_s ? acc_r[rd_ctx][rd_idx_s] : '0;
    end
  end

  assign in_ready          = in_ready_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign rd_valid          = rd_valid_r;
  assign rd_data           = rd_data_r;
  assign sat_flags         = sat_flags_r;
  assign cycle_count       = cycle_r;
  assign stall_count       = stall_r;
  assign utilization_count = util_r;

endmodule
